fifo_sync_prog: RTL and testbench
=================================

# fifo_sync_prog

Parametrised single-clock FIFO. It is the synchronous successor to the team's dual-clock FIFO top and serves blocks that share one clock domain. Beyond the full/empty/half flags it adds:
- an occupancy count,
- run-time programmable almost-full and almost-empty thresholds,
- sticky overflow and underflow error flags,
- a compile-time first-word-fall-through (FWFT) read mode.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 6, log2 of depth; DEPTH = 2**ADDR_WIDTH (64 by default)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request (read acknowledge in FWFT mode)
- data_out  out  DATA_WIDTH  read data
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold
- clr_err  in  1  clears the sticky error flags
- full, empty, half  out  1 each  occupancy flags
- almost_full, almost_empty  out  1 each  threshold flags
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Storage: a register array of DEPTH words. The array is not reset.
- Pointers: wptr and rptr are ADDR_WIDTH bits wide. They wrap modulo DEPTH naturally.
- count register: ADDR_WIDTH+1 bits; the single source of truth for all flags.
- Write acceptance: wr_ok = wr_en & ~full. On wr_ok, mem[wptr] <= data_in and wptr increments.
- Read acceptance: rd_ok = rd_en & ~empty. On rd_ok, rptr increments.
- count update:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither occur
- Flag decodes, all combinational from registered count and the threshold inputs:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - half = (count >= DEPTH/2)
  - almost_full = (count >= af_thresh)
  - almost_empty = (count <= ae_thresh)
- Simultaneous read and write:
  - When 0 < count < DEPTH, both operations are accepted and count holds.
  - When empty, only the write is accepted; underflow sets.
  - When full, only the read is accepted; overflow sets. A write is never accepted into a full FIFO, even if a read is accepted in the same cycle.
- Error flags:
  - overflow sets on wr_en & full.
  - underflow sets on rd_en & empty.
  - Both clear on clr_err or rst. A set condition wins over clr_err in the same cycle.
  - Rejected operations change no pointer, count or data.
- Threshold inputs are used live; a change in either threshold affects its flag in the same cycle. Threshold values above DEPTH are legal:
  - af_thresh > DEPTH means almost_full never asserts.
  - ae_thresh >= DEPTH means almost_empty is always asserted.

## Timing
- Reset values: wptr = 0, rptr = 0, count = 0, data_out = 0, overflow = 0, underflow = 0.
  - Resulting flags: empty = 1, full = 0, half = 0, almost_empty = 1.
  - almost_full = (af_thresh == 0).
- Reset mid-operation discards all contents. Any wr_en or rd_en in the reset cycle is ignored.
- Write to flag latency: a write in cycle N updates count, empty and full at edge N+1.
- Standard read mode:
  - data_out is registered and loads mem[rptr] on rd_ok.
  - Data is valid the cycle after the accepted read.
  - data_out holds its value when there is no rd_ok.
- Full-to-nonfull and empty-to-nonempty transitions each take exactly one edge. There is no synchronizer delay.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- FIFO_FWFT_EN defined:
  - data_out = mem[rptr] combinationally, valid whenever empty = 0.
  - rd_en acknowledges the word currently shown; the next word appears after the edge.
  - A word written into an empty FIFO appears on data_out one cycle after the write, together with empty falling.
  - data_out after reset is undefined; the bench must not check it while empty = 1.
- FIFO_FWFT_EN undefined: standard registered-read behaviour as described under Timing.
- Flags, count and error logic are identical in both modes.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4 (DEPTH 16).
- Fill and drain: write 0x00..0x0F.
  - After the 16th write: full=1, count=16, half=1.
  - Reading returns 0x00..0x0F in order; after the last read, empty=1.
- Overflow and clear: with the FIFO full, pulse wr_en with 0xAA.
  - overflow=1, count stays 16, and 0xAA is never read out.
  - clr_err clears overflow the next cycle.
- Underflow with simultaneous write: FIFO empty, rd_en=wr_en=1 with 0x55.
  - underflow=1 and count=1.
  - The next read returns 0x55.
- Thresholds: af_thresh=12, ae_thresh=3, write 12 words.
  - almost_empty falls when count reaches 4.
  - almost_full rises when count reaches 12.
  - Changing af_thresh to 13 drops almost_full the same cycle.
- Wrap and concurrency:
  - Run 100 cycles of simultaneous read and write at count=8.
  - Check: count stays 8, data order is preserved across pointer wrap, and no error flags are raised.
- Reset mid-stream: assert rst with count=9.
  - Next cycle: count=0, empty=1, error flags=0.
  - The first word written after reset is the first word read.

Source files
------------

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with an occupancy count, programmable
// almost-full/almost-empty thresholds, and sticky overflow/underflow flags.
// Every flag is decoded from the registered count, so there is only one
// source of truth for occupancy.
// Optional feature: define FIFO_FWFT_EN for first-word-fall-through reads.
// In that mode data_out shows the head word combinationally and rd_en
// acknowledges it. Without the macro, data_out is a registered read port.
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  input  logic                  clr_err,
  output logic                  full,
  output logic                  empty,
  output logic                  half,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] HALF_CNT  = (ADDR_WIDTH+1)'(DEPTH / 2);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // A write into a full FIFO is refused even when a read frees a slot in the
  // same cycle, so acceptance looks only at the registered flags.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Occupancy flags decoded from the registered count and the live thresholds
  always_comb begin
    full         = (count == DEPTH_CNT);
    empty        = (count == '0);
    half         = (count >= HALF_CNT);
    almost_full  = (count >= af_thresh);
    almost_empty = (count <= ae_thresh);
  end

  // Storage array; it has no reset because the pointers define valid contents
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wptr] <= data_in;
    end
  end

  // Pointers and occupancy count. Rejected operations leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a fresh error in the same cycle beats clr_err
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is always visible; rd_en pops it and the next word shows after the edge
  assign data_out = mem[rptr];
`else
  // Registered read port that holds its last value between accepted reads
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= mem[rptr];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb_fifo_sync_prog: self-checking bench for fifo_sync_prog (DEPTH 16).
// Uses a vector table, directed corner-case sequences, and randomized traffic
// checked against a queue-based reference model.
// Honours FIFO_FWFT_EN when it is defined for the build.
module tb_fifo_sync_prog;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [AW:0]   af_thresh = 5'd0;
  logic [AW:0]   ae_thresh = 5'd3;
  logic [AW:0]   count;
  logic          full, empty, half, almost_full, almost_empty;
  logic          overflow, underflow;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the FIFO contents as a plain queue plus the sticky bits
  logic [DW-1:0] model_q [$];
  bit            model_ov;
  bit            model_un;
  logic [DW-1:0] model_dout;

  typedef struct {
    bit            rst;
    bit            wr;
    logic [DW-1:0] din;
    bit            rd;
    bit            clr;
    int            exp_count;
    bit            exp_ae;
    bit            exp_af;
    bit            exp_un;
    bit            exp_ov;
  } vec_t;

  vec_t vecs [8];

  fifo_sync_prog #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .clr_err     (clr_err),
    .full        (full),
    .empty       (empty),
    .half        (half),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Time limit so the run can never hang
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=time limit reached, required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports a failure line on mismatch
  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Drive one clock cycle of inputs, advance the model, sample #1 after the edge
  task automatic applyStimulus(input bit wr, input logic [DW-1:0] din, input bit rd,
                               input bit clr, input bit rs);
    int n;
    rst     = rs;
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    clr_err = clr;
    n = model_q.size();
    if (rs) begin
      model_q.delete();
      model_ov   = 1'b0;
      model_un   = 1'b0;
      model_dout = '0;
    end else begin
      if (wr && n == DEPTH) model_ov = 1'b1;
      else if (clr)         model_ov = 1'b0;
      if (rd && n == 0)     model_un = 1'b1;
      else if (clr)         model_un = 1'b0;
      if (rd && n > 0)      model_dout = model_q.pop_front();
      if (wr && n < DEPTH)  model_q.push_back(din);
    end
    @(posedge clk);
    #1;
    rst     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  // Compare every output against the reference model
  task automatic checkModel(input string tag);
    int n;
    n = model_q.size();
    checkOutput({tag, ".count"},        int'(count),        n);
    checkOutput({tag, ".full"},         int'(full),         int'(n == DEPTH));
    checkOutput({tag, ".empty"},        int'(empty),        int'(n == 0));
    checkOutput({tag, ".half"},         int'(half),         int'(n >= DEPTH / 2));
    checkOutput({tag, ".almost_full"},  int'(almost_full),  int'(n >= int'(af_thresh)));
    checkOutput({tag, ".almost_empty"}, int'(almost_empty), int'(n <= int'(ae_thresh)));
    checkOutput({tag, ".overflow"},     int'(overflow),     int'(model_ov));
    checkOutput({tag, ".underflow"},    int'(underflow),    int'(model_un));
`ifdef FIFO_FWFT_EN
    if (n > 0) checkOutput({tag, ".data_out"}, int'(data_out), int'(model_q[0]));
`else
    checkOutput({tag, ".data_out"}, int'(data_out), int'(model_dout));
`endif
  endtask

  // Pop one word and compare it with a bench-chosen constant
  task automatic readCheck(input string name, input logic [DW-1:0] expected);
`ifdef FIFO_FWFT_EN
    checkOutput(name, int'(data_out), int'(expected));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
`else
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput(name, int'(data_out), int'(expected));
`endif
  endtask

  initial begin
    int wr_pct;
    int rd_pct;

    // Vector table: {rst, wr, din, rd, clr, count, almost_empty, almost_full, underflow, overflow}
    // with af_thresh=2 and ae_thresh=1, starting from an empty FIFO
    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset.count", int'(count), 0);
    checkOutput("reset.empty", int'(empty), 1);
    checkOutput("reset.full", int'(full), 0);
    checkOutput("reset.half", int'(half), 0);
    checkOutput("reset.almost_empty", int'(almost_empty), 1);
    checkOutput("reset.almost_full_thresh0", int'(almost_full), 1);
    checkOutput("reset.overflow", int'(overflow), 0);
    checkOutput("reset.underflow", int'(underflow), 0);
`ifndef FIFO_FWFT_EN
    checkOutput("reset.data_out", int'(data_out), 0);
`endif
    af_thresh = 5'd16;
    #1;
    checkOutput("reset.almost_full_thresh16", int'(almost_full), 0);

    // Table-driven vectors
    af_thresh = 5'd2;
    ae_thresh = 5'd1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr, vecs[i].rst);
      checkOutput($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_count);
      checkOutput($sformatf("vec%0d.almost_empty", i), int'(almost_empty), int'(vecs[i].exp_ae));
      checkOutput($sformatf("vec%0d.almost_full", i), int'(almost_full), int'(vecs[i].exp_af));
      checkOutput($sformatf("vec%0d.underflow", i), int'(underflow), int'(vecs[i].exp_un));
      checkOutput($sformatf("vec%0d.overflow", i), int'(overflow), int'(vecs[i].exp_ov));
    end

    // Fill and drain
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("fill.full", int'(full), 1);
    checkOutput("fill.count", int'(count), 16);
    checkOutput("fill.half", int'(half), 1);
    for (int i = 0; i < DEPTH; i++) readCheck($sformatf("drain.word%0d", i), 8'(i));
    checkOutput("drain.empty", int'(empty), 1);

    // Overflow and clear
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf.overflow", int'(overflow), 1);
    checkOutput("ovf.count", int'(count), 16);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("ovf.cleared", int'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) readCheck($sformatf("ovf.word%0d", i), 8'(8'h10 + i));
    checkOutput("ovf.empty", int'(empty), 1);

    // Underflow with simultaneous write
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    checkOutput("unf.underflow", int'(underflow), 1);
    checkOutput("unf.count", int'(count), 1);
    readCheck("unf.word", 8'h55);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkModel("unf.model");

    // Thresholds
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("thr.ae_at%0d", k), int'(almost_empty), int'(k <= 3));
      checkOutput($sformatf("thr.af_at%0d", k), int'(almost_full), int'(k >= 12));
    end
    af_thresh = 5'd13;
    #1;
    checkOutput("thr.af_live_change", int'(almost_full), 0);

    // Wrap and concurrency at count 8
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 8; j++) applyStimulus(1'b1, 8'((j * 7 + 3) & 8'hFF), 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 100; j++) begin
`ifdef FIFO_FWFT_EN
      checkOutput($sformatf("wrap.word%0d", j), int'(data_out), (j * 7 + 3) & 8'hFF);
      applyStimulus(1'b1, 8'(((j + 8) * 7 + 3) & 8'hFF), 1'b1, 1'b0, 1'b0);
`else
      applyStimulus(1'b1, 8'(((j + 8) * 7 + 3) & 8'hFF), 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("wrap.word%0d", j), int'(data_out), (j * 7 + 3) & 8'hFF);
`endif
      checkOutput($sformatf("wrap.count%0d", j), int'(count), 8);
    end
    checkOutput("wrap.overflow", int'(overflow), 0);
    checkOutput("wrap.underflow", int'(underflow), 0);

    // Reset mid-stream, with requests present in the reset cycle
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid.count_before", int'(count), 9);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    checkOutput("rstmid.count", int'(count), 0);
    checkOutput("rstmid.empty", int'(empty), 1);
    checkOutput("rstmid.overflow", int'(overflow), 0);
    checkOutput("rstmid.underflow", int'(underflow), 0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    readCheck("rstmid.first_word", 8'hC3);

    // Randomized traffic against the reference model
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    wr_pct = 50;
    rd_pct = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) begin
        wr_pct = 20 + 30 * int'($urandom_range(0, 2));
        rd_pct = 20 + 30 * int'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 49) == 0) begin
        af_thresh = 5'($urandom_range(0, 20));
        ae_thresh = 5'($urandom_range(0, 20));
      end
      applyStimulus(int'($urandom_range(0, 99)) < wr_pct, 8'($urandom),
                    int'($urandom_range(0, 99)) < rd_pct,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
      checkModel($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
